serial_addsub_seq: RTL and testbench
====================================

// Module: serial_addsub_seq
// PURPOSE
//  Parametrised digit-serial adder/subtractor. Successor to the 1-bit JK serial adder.
//  Loads two WIDTH-bit operands and processes DIGIT bits per clock, LSB first.
//  Keeps a single carry/borrow register between steps.
//  Reports sum, carry-out and signed overflow, with a start/busy/done handshake.
//  Sits between the operand registers and the result bus in the serial datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
//  DIGIT  1  bits processed per clock; must divide WIDTH exactly; STEPS = WIDTH/DIGIT
// PORTS
//  clk    in   1      clock; all state updates on its rising edge
//  clr_n  in   1      reset, asynchronous, active-low
//  start  in   1      request; sampled only when busy=0
//  sub    in   1      0: a+b, 1: a-b (computed as a + ~b + 1); sampled with start
//  a      in   WIDTH  operand A; sampled with start
//  b      in   WIDTH  operand B; sampled with start
//  busy   out  1      high while a computation is in progress (state RUN)
//  done   out  1      one-cycle pulse; result outputs are valid from this cycle
//  sum    out  WIDTH  result; held until the next accepted start
//  cout   out  1      carry out of MSB; for sub: 1 = no borrow (a >= b unsigned)
//  ovf    out  1      two's-complement overflow = carry into MSB ^ carry out of MSB
// BEHAVIOUR
//  Reset (clr_n=0, any time, including mid-operation):
//   - state=IDLE
//   - busy=0, done=0, sum=0, cout=0, ovf=0
//   - shift registers, carry and step counter cleared
//   - an in-flight operation is discarded
//  States:
//   - IDLE: start=1 -> RUN. Load A shift reg <= a, B shift reg <= (sub ? ~b : b),
//     carry <= sub, cnt <= 0.
//   - RUN: each cycle adds the DIGIT LSBs of A and B plus carry.
//     - Result digit shifts into the sum register from the MSB side.
//     - A and B shift right by DIGIT; carry <= digit carry-out; cnt++.
//     - When cnt==STEPS-1 -> DONE. On this step, capture cout and ovf; the
//       carry into the MSB comes from the MSB column of the final digit.
//   - DONE: done=1 for exactly one cycle, busy=0.
//     - start=1 -> RUN (back-to-back accept, new load as in IDLE).
//     - Otherwise -> IDLE.
//  Latency:
//   - start accepted at edge N; busy=1 from N+1 for STEPS cycles.
//   - done=1 in the cycle after edge N+STEPS.
//   - Throughput: one op per STEPS+1 cycles.
//  start while busy=1 is ignored (no queueing, no error). sub, a and b are don't-care
//  outside the accept cycle.
//  sum changes only during RUN. Intermediate values are visible but not valid until done.
//  cout and ovf update only on the final step; held until the next final step.
//  Arithmetic is modulo 2^WIDTH. Wrap-around (0xFF+0x01) gives sum=0, cout=1, ovf=0.
// CONFIGURATION
//  SERIAL_ADDSUB_SAT_EN defined:
//   - On the final step, if ovf=1, sum is clamped to a signed limit:
//     - 0x7F..F when the true result is positive (operand A MSB = 0)
//     - 0x80..0 when the true result is negative (operand A MSB = 1)
//   - ovf and cout are still reported unchanged. The clamp adds no cycle of latency.
//  SERIAL_ADDSUB_SAT_EN undefined:
//   - sum is always the wrapped modulo result. No clamp logic is instantiated.
// TESTING (WIDTH=8; DIGIT=1 unless stated)
//  1. Reset: clr_n=0 -> all outputs 0.
//     Release, start with a=0x05, b=0x03, sub=0 -> busy for 8 cycles, then done=1,
//     sum=0x08, cout=0, ovf=0.
//  2. Subtract: a=0x03, b=0x05, sub=1 -> sum=0xFE, cout=0 (borrow), ovf=0.
//     Then a=0x05, b=0x03, sub=1 -> sum=0x02, cout=1.
//  3. Overflow: a=0x7F, b=0x01, sub=0 -> ovf=1, cout=0.
//     Without SERIAL_ADDSUB_SAT_EN: sum=0x80. With it: sum=0x7F.
//     a=0xFF, b=0x01 -> sum=0x00, cout=1, ovf=0.
//  4. Handshake: pulse start during RUN with different operands -> ignored, original
//     result returned.
//     Assert start in the done cycle -> new op accepted, busy=1 on the next cycle.
//  5. Reset mid-op: drop clr_n at step 4 -> outputs 0 immediately (asynchronous).
//     After release the block is idle; a new start completes correctly.
//  6. DIGIT=4: a=0x9C, b=0x47, sub=0 -> done 2 cycles after busy rises,
//     sum=0xE3, cout=0, ovf=0.

Source files
------------

// File: rtl/serial_addsub_seq_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
// The requester drives start/sub/a/b; the datapath returns status and result.
interface serial_addsub_seq_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, a, b,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/serial_addsub_seq.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, one carry register.
// Optional signed saturation of the result is enabled by defining SERIAL_ADDSUB_SAT_EN.
module serial_addsub_seq #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input logic                clk,
   input logic                clr_n,
   serial_addsub_seq_if.slave bus
);

   localparam int unsigned STEPS = WIDTH / DIGIT;
   localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_q;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             busy_q;
   logic             done_q;
   logic             cout_q;
   logic             ovf_q;

   logic [DIGIT:0]   dig_c;
   logic             msb_cin_c;
   logic             dig_ovf_c;
   logic [WIDTH-1:0] sum_shift_c;
   logic [WIDTH-1:0] sum_fin_c;

   // One digit column sum; the carry into the top bit is recovered from its sum bit.
   always_comb begin
      dig_c       = (DIGIT+1)'(a_sr[DIGIT-1:0]) + (DIGIT+1)'(b_sr[DIGIT-1:0])
                    + (DIGIT+1)'(carry);
      msb_cin_c   = dig_c[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1];
      dig_ovf_c   = msb_cin_c ^ dig_c[DIGIT];
      sum_shift_c = WIDTH'({dig_c[DIGIT-1:0], sum_q} >> DIGIT);
      sum_fin_c   = sum_shift_c;
`ifdef SERIAL_ADDSUB_SAT_EN
      // On the last digit a_sr[DIGIT-1] is the original sign of operand A.
      if (dig_ovf_c) begin
         sum_fin_c = a_sr[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_q  <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  state  <= RUN;
                  busy_q <= 1'b1;
                  a_sr   <= bus.a;
                  b_sr   <= bus.sub ? ~bus.b : bus.b;
                  carry  <= bus.sub;
                  cnt    <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sr  <= a_sr >> DIGIT;
               b_sr  <= b_sr >> DIGIT;
               carry <= dig_c[DIGIT];
               cnt   <= cnt + CNT_W'(1);
               if (cnt == LAST_STEP) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  cout_q <= dig_c[DIGIT];
                  ovf_q  <= dig_ovf_c;
                  sum_q  <= sum_fin_c;
               end else begin
                  sum_q <= sum_shift_c;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Bench for serial_addsub_seq: DIGIT=1 and DIGIT=4 instances, directed table,
// handshake/reset sequences and random ops against an arithmetic reference model.
module tb_serial_addsub_seq;

   localparam int unsigned W = 8;

   logic clk   = 1'b0;
   logic clr_n = 1'b0;
   always #5 clk = ~clk;

   serial_addsub_seq_if #(.WIDTH(W)) if1 ();
   serial_addsub_seq_if #(.WIDTH(W)) if4 ();

   serial_addsub_seq #(.WIDTH(W), .DIGIT(1)) dut1 (.clk(clk), .clr_n(clr_n), .bus(if1.slave));
   serial_addsub_seq #(.WIDTH(W), .DIGIT(4)) dut4 (.clk(clk), .clr_n(clr_n), .bus(if4.slave));

`ifdef SERIAL_ADDSUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input int dg, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic sub);
      if (dg == 1) begin
         if1.start = s; if1.a = a; if1.b = b; if1.sub = sub;
      end else begin
         if4.start = s; if4.a = a; if4.b = b; if4.sub = sub;
      end
   endtask

   // {busy, done, cout, ovf, sum}
   function automatic logic [11:0] obs(input int dg);
      if (dg == 1) return {if1.busy, if1.done, if1.cout, if1.ovf, if1.sum};
      return {if4.busy, if4.done, if4.cout, if4.ovf, if4.sum};
   endfunction

   // Reference: {cout, ovf, sum} from plain integer arithmetic.
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic sub);
      int unsigned ua, ub, full;
      int          sa, sb, tr;
      logic [7:0]  s;
      logic        c, o;
      ua   = a;
      ub   = b;
      full = sub ? ua + (255 - ub) + 1 : ua + ub;
      c    = full > 255;
      s    = 8'(full % 256);
      sa   = $signed(a);
      sb   = $signed(b);
      tr   = sub ? sa - sb : sa + sb;
      o    = (tr > 127) || (tr < -128);
      if (SAT && o) s = (tr > 0) ? 8'h7F : 8'h80;
      return {c, o, s};
   endfunction

   task automatic wait_done(input int dg, output int lat);
      logic [11:0] o;
      lat = 0;
      o   = obs(dg);
      while (!o[10] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         o = obs(dg);
      end
   endtask

   // Called 1 time unit after a rising edge with the DUT idle or in its done cycle.
   task automatic run_op(input int dg, input logic [7:0] a, input logic [7:0] b, input logic sub,
                         output logic [7:0] s, output logic c, output logic ov, output int lat);
      logic [11:0] o;
      drive(dg, 1'b1, a, b, sub);
      @(posedge clk); #1;
      drive(dg, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      o = obs(dg);
      check($sformatf("busy_after_accept_d%0d", dg), 32'(o[11]), 32'd1);
      wait_done(dg, lat);
      o  = obs(dg);
      s  = o[7:0];
      c  = o[9];
      ov = o[8];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs [8];
      logic [7:0]  s;
      logic        c, ov;
      int          lat;
      logic [9:0]  m;
      logic [11:0] o;

      vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
      vecs[1] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0};
      vecs[2] = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0};
      vecs[3] = '{8'h7F, 8'h01, 1'b0, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1};
      vecs[4] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[5] = '{8'h9C, 8'h47, 1'b0, 8'hE3, 1'b0, 1'b0};
      vecs[6] = '{8'h80, 8'h01, 1'b1, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1};
      vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

      drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
      drive(4, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs_d1", 32'(obs(1)), 32'd0);
      check("reset_outs_d4", 32'(obs(4)), 32'd0);
      clr_n = 1'b1;
      @(posedge clk); #1;

      // Directed table on both digit sizes, plus hold-after-done check.
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 2; k++) begin
            int dg;
            dg = (k == 0) ? 1 : 4;
            run_op(dg, vecs[i].a, vecs[i].b, vecs[i].sub, s, c, ov, lat);
            check($sformatf("vec%0d_d%0d_latency", i, dg), 32'(lat), 32'(8 / dg));
            check($sformatf("vec%0d_d%0d_sum", i, dg), 32'(s), 32'(vecs[i].sum));
            check($sformatf("vec%0d_d%0d_cout", i, dg), 32'(c), 32'(vecs[i].cout));
            check($sformatf("vec%0d_d%0d_ovf", i, dg), 32'(ov), 32'(vecs[i].ovf));
            @(posedge clk); #1;
            o = obs(dg);
            check($sformatf("vec%0d_d%0d_hold", i, dg), 32'(o),
                  32'({2'b00, vecs[i].cout, vecs[i].ovf, vecs[i].sum}));
         end
      end

      // start during RUN is ignored.
      drive(1, 1'b1, 8'h05, 8'h03, 1'b0);
      @(posedge clk); #1;
      drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      drive(1, 1'b1, 8'h40, 8'h40, 1'b1);
      @(posedge clk); #1;
      drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
      wait_done(1, lat);
      o = obs(1);
      check("ignore_start_sum", 32'(o[7:0]), 32'h08);
      check("ignore_start_flags", 32'(o[9:8]), 32'd0);

      // Start asserted in the done cycle is accepted back-to-back.
      run_op(1, 8'h10, 8'h20, 1'b0, s, c, ov, lat);
      check("b2b_latency", 32'(lat), 32'd8);
      check("b2b_sum", 32'(s), 32'h30);

      // Asynchronous reset in the middle of an operation.
      @(posedge clk); #1;
      run_op(1, 8'hFF, 8'h01, 1'b0, s, c, ov, lat);
      check("pre_reset_cout", 32'(c), 32'd1);
      drive(1, 1'b1, 8'h05, 8'h03, 1'b0);
      @(posedge clk); #1;
      drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (4) @(posedge clk);
      #2;
      o = obs(1);
      check("midop_busy", 32'(o[11]), 32'd1);
      clr_n = 1'b0;
      #1;
      check("midop_reset_outs", 32'(obs(1)), 32'd0);
      @(posedge clk); #1;
      clr_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_idle", 32'(obs(1)), 32'd0);
      run_op(1, 8'h9C, 8'h47, 1'b0, s, c, ov, lat);
      check("post_reset_latency", 32'(lat), 32'd8);
      check("post_reset_sum", 32'(s), 32'hE3);

      // Random ops, consecutive on one instance so each start lands in a done cycle.
      for (int i = 0; i < 160; i++) begin
         int         dg;
         logic [7:0] ra, rb;
         logic       rs;
         dg = (i < 80) ? 1 : 4;
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 1'($urandom);
         if (i == 80) begin
            @(posedge clk); #1;
         end
         m = model(ra, rb, rs);
         run_op(dg, ra, rb, rs, s, c, ov, lat);
         check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(8 / dg));
         check($sformatf("rnd%0d_result a=%0h b=%0h sub=%0b", i, ra, rb, rs),
               32'({c, ov, s}), 32'(m));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
